// File: rtl/traffic_light_monitor.sv
// Passive safety watchdog for a 4-way traffic light controller: checks lamp
// one-hotness and the green/yellow/red round-robin, latches the first fault.
//   state     | meaning
//   S_SYNC    | waiting for first green to lock onto
//   S_GREEN   | locked direction green, counting samples
//   S_YELLOW  | locked direction yellow, counting samples
//   S_ALL_RED | all red, waiting for next direction's green
//   S_FAULT   | first violation latched, absorbing until reset
module traffic_light_monitor #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 7,
  parameter int YEL_CYC   = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r,
  input  logic [3:0] y,
  input  logic [3:0] g,
  output logic       locked,
  output logic [1:0] active_dir,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_GREEN,
    S_YELLOW,
    S_ALL_RED,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_LEN = CNT_W'(YEL_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       r_q, y_q, g_q, r_p, y_p, g_p;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       fdir_q, fdir_d;
  logic [7:0]       cyc_q, cyc_d;

  logic [3:0]       act, oh_bad, trans_bad;
  logic             multi;
  logic [1:0]       exp_dir;
  logic [2:0]       v_code;
  logic [1:0]       v_dir;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign act       = y_q | g_q;
  // exactly one of r/y/g: odd parity but not all three
  assign oh_bad    = ~((r_q ^ y_q ^ g_q) & ~(r_q & y_q & g_q));
  assign multi     = (act & (act - 4'd1)) != 4'd0;
  assign trans_bad = (g_p & r_q) | (r_p & y_q) | (y_p & g_q);
  assign exp_dir   = dir_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      y_q      <= '0;
      g_q      <= '0;
      r_p      <= '0;
      y_p      <= '0;
      g_p      <= '0;
      vld_q    <= 1'b0;
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      dir_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= '0;
      fdir_q   <= '0;
      cyc_q    <= '0;
    end else begin
      r_q      <= r;
      y_q      <= y;
      g_q      <= g;
      r_p      <= r_q;
      y_p      <= y_q;
      g_p      <= g_q;
      vld_q    <= 1'b1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      fdir_q   <= fdir_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    code_d   = code_q;
    fdir_d   = fdir_q;
    cyc_d    = cyc_q;
    v_code   = 3'd0;
    v_dir    = 2'd0;

    if (vld_q && state_q != S_FAULT) begin
      if (|oh_bad) begin
        v_code = 3'd1;
        v_dir  = lowest(oh_bad);
      end else if (multi) begin
        v_code = 3'd2;
        v_dir  = lowest(act);
      end else begin
        case (state_q)
          S_SYNC: begin
            if (|g_q) begin
              state_d  = S_GREEN;
              cnt_d    = ONE;
              dir_d    = lowest(g_q);
              locked_d = 1'b1;
            end
          end
          S_GREEN: begin
            if (g_q[dir_q]) begin
              if (cnt_q == G_MAX) begin
                v_code = 3'd5;
                v_dir  = dir_q;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else if (y_q[dir_q]) begin
              if (cnt_q < G_MIN) begin
                v_code = 3'd4;
                v_dir  = dir_q;
              end else begin
                state_d = S_YELLOW;
                cnt_d   = ONE;
              end
            end else if (cnt_q < G_MIN) begin
              v_code = 3'd4;
              v_dir  = dir_q;
            end else begin
              v_code = 3'd7;
              v_dir  = lowest(trans_bad);
            end
          end
          S_YELLOW: begin
            if (y_q[dir_q]) begin
              if (cnt_q == Y_LEN) begin
                v_code = 3'd6;
                v_dir  = dir_q;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else if (g_q[dir_q]) begin
              v_code = 3'd7;
              v_dir  = dir_q;
            end else if (|g_q && !g_q[exp_dir]) begin
              v_code = 3'd3;
              v_dir  = lowest(g_q);
            end else if (cnt_q != Y_LEN) begin
              v_code = 3'd6;
              v_dir  = dir_q;
            end else if (|trans_bad) begin
              v_code = 3'd7;
              v_dir  = lowest(trans_bad);
            end else begin
              if (dir_q == 2'd3) cyc_d = cyc_q + 8'd1;
              // zero all-red samples is legal: next green may follow directly
              if (|g_q) begin
                state_d = S_GREEN;
                cnt_d   = ONE;
                dir_d   = exp_dir;
              end else begin
                state_d = S_ALL_RED;
              end
            end
          end
          S_ALL_RED: begin
            if (|g_q) begin
              if (g_q[exp_dir]) begin
                state_d = S_GREEN;
                cnt_d   = ONE;
                dir_d   = exp_dir;
              end else begin
                v_code = 3'd3;
                v_dir  = lowest(g_q);
              end
            end else if (|y_q) begin
              v_code = 3'd7;
              v_dir  = lowest(trans_bad);
            end
          end
          default: ;
        endcase
      end

      if (v_code != 3'd0) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        code_d  = v_code;
        fdir_d  = v_dir;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        cyc_d   = cyc_q;
      end
    end
  end

  assign locked     = locked_q;
  assign active_dir = dir_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = fdir_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: generated lamp phases with random lengths;
// expected faults/counters follow from the phase lengths the bench chose.
module tb_traffic_light_monitor;

  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 7;
  localparam int YEL_CYC   = 2;
  localparam int CNT_W     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] r = 4'hF, y = 4'h0, g = 4'h0;
  logic       locked, fault;
  logic [1:0] active_dir, fault_dir;
  logic [2:0] fault_code;
  logic [7:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  // reference state: what the outputs must show once the last sample is judged
  bit         m_fault, m_locked;
  int         m_code, m_cyc;
  logic [1:0] m_dir, m_act;
  // consequence of a phase ending, judged on the following sample
  int         c_code;
  logic [1:0] c_dir;
  bit         c_cyc;

  traffic_light_monitor #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YEL_CYC(YEL_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .r(r), .y(y), .g(g),
    .locked(locked), .active_dir(active_dir), .fault(fault),
    .fault_code(fault_code), .fault_dir(fault_dir), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("fault_code", {29'd0, fault_code}, m_code);
    chk("fault_dir", {30'd0, fault_dir}, {30'd0, m_dir});
    chk("cycle_cnt", {24'd0, cycle_cnt}, m_cyc);
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("active_dir", {30'd0, active_dir}, {30'd0, m_act});
  endtask

  task automatic model_clear();
    m_fault = 0; m_locked = 0; m_code = 0; m_cyc = 0; m_dir = 0; m_act = 0;
    c_code = 0; c_dir = 0; c_cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; r = 4'hF; y = 4'h0; g = 4'h0;
    @(posedge clk); #1;
    model_clear();
    check_all();
    reset = 1'b0;
  endtask

  // drive one sample; outputs after this edge reflect the previous sample
  task automatic emit(input logic [3:0] rr, input logic [3:0] yy, input logic [3:0] gg,
                      input int code, input logic [1:0] cdir, input bit lock);
    int fc;
    logic [1:0] fd;
    bit cyc;
    fc = code; fd = cdir; cyc = c_cyc;
    if (c_code != 0 && (fc == 0 || c_code < fc)) begin
      fc = c_code; fd = c_dir;
    end
    c_code = 0; c_cyc = 0;
    r = rr; y = yy; g = gg;
    @(posedge clk); #1;
    check_all();
    if (!m_fault) begin
      if (fc != 0) begin
        m_fault = 1; m_code = fc; m_dir = fd;
      end else begin
        if (cyc) m_cyc = (m_cyc + 1) % 256;
        if (lock) begin m_locked = 1; m_act = cdir; end
      end
    end
  endtask

  task automatic greens(input logic [1:0] d, input int n);
    for (int k = 1; k <= n; k++) begin
      int code;
      logic [1:0] nx;
      code = 0;
      nx = m_act + 2'd1;
      if (k == 1 && m_locked && d != nx) code = 3;
      if (k == GREEN_MAX + 1) code = 5;
      emit(~(4'b0001 << d), 4'b0000, 4'b0001 << d, code, d, k == 1);
    end
  endtask

  task automatic yellows(input logic [1:0] d, input int glen, input int n);
    for (int k = 1; k <= n; k++) begin
      int code;
      code = 0;
      if (k == 1 && glen < GREEN_MIN) code = 4;
      else if (k == YEL_CYC + 1) code = 6;
      emit(~(4'b0001 << d), 4'b0001 << d, 4'b0000, code, d, 1'b0);
    end
    if (n == 0) begin
      c_code = (glen < GREEN_MIN) ? 4 : 7; c_dir = d;
    end else if (n < YEL_CYC) begin
      c_code = 6; c_dir = d;
    end else begin
      c_cyc = (d == 2'd3);
    end
  endtask

  task automatic reds(input int n);
    for (int k = 0; k < n; k++) emit(4'hF, 4'h0, 4'h0, 0, 2'd0, 1'b0);
  endtask

  task automatic phase(input logic [1:0] d, input int glen, input int ylen, input int arlen);
    greens(d, glen);
    yellows(d, glen, ylen);
    reds(arlen);
  endtask

  initial begin
    logic [1:0] sd;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // legal stream: 3 rounds of green 6 / yellow 2 / 1 all-red
    reds($urandom_range(0, 3));
    for (int rnd = 0; rnd < 3; rnd++)
      for (int d = 0; d < 4; d++) phase(2'(d), 6, YEL_CYC, 1);
    reds(1);
    chk("cycles_after_3_rounds", {24'd0, cycle_cnt}, 3);

    // long random legal run, wraps cycle_cnt past 255
    for (int i = 0; i < 1030; i++)
      phase(2'(i % 4), $urandom_range(GREEN_MIN, GREEN_MAX), YEL_CYC, $urandom_range(0, 2));
    reds(1);

    // two directions active, later violations ignored
    do_reset();
    sd = 2'($urandom_range(0, 3));
    phase(sd, 6, YEL_CYC, 1);
    greens(sd + 2'd1, 2);
    emit(4'b1100, 4'b0000, 4'b0011, 2, 2'd0, 1'b0);
    emit(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 1'b0);
    emit(4'b1111, 4'b0000, 4'b0000, 0, 2'd0, 1'b0);
    chk("code2_held", {29'd0, fault_code}, 2);

    // green too long on direction 2
    do_reset();
    phase(2'd0, 6, YEL_CYC, 1);
    greens(2'd1, 8);
    reds(1);

    // green too short
    do_reset();
    sd = 2'($urandom_range(0, 3));
    phase(sd, 6, YEL_CYC, 0);
    phase(sd + 2'd1, 4, YEL_CYC, 2);

    // wrong direction after all-red, then directly after yellow
    do_reset();
    phase(2'd0, 6, YEL_CYC, 1);
    greens(2'd2, 3);
    do_reset();
    sd = 2'($urandom_range(0, 3));
    phase(sd, $urandom_range(GREEN_MIN, GREEN_MAX), YEL_CYC, 0);
    greens(sd + 2'd2, 2);

    // red and green together on direction 1
    do_reset();
    phase(2'd3, 6, YEL_CYC, 1);
    emit(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 1'b0);
    reds(1);

    // yellow too long, yellow too short
    do_reset();
    sd = 2'($urandom_range(0, 3));
    phase(sd, 6, 3, 2);
    do_reset();
    phase(sd, 6, 1, 2);

    // green straight to red, and red straight to yellow
    do_reset();
    sd = 2'($urandom_range(0, 3));
    phase(sd, 6, 0, 2);
    do_reset();
    phase(sd, 6, YEL_CYC, 1);
    emit(~(4'b0001 << (sd + 2'd1)), 4'b0001 << (sd + 2'd1), 4'b0000, 7, sd + 2'd1, 1'b0);
    reds(1);

    // fault, reset pulse mid-round, then clean re-lock
    do_reset();
    phase(2'd1, 6, YEL_CYC, 1);
    greens(2'd2, 3);
    emit(4'b0011, 4'b0000, 4'b1100, 2, 2'd2, 1'b0);
    reds(1);
    do_reset();
    reds(2);
    sd = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++)
      phase(sd + 2'(i), $urandom_range(GREEN_MIN, GREEN_MAX), YEL_CYC, $urandom_range(0, 2));
    reds(1);
    chk("no_fault_after_reset", {31'd0, fault}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the receiving end of the 4-way traffic light controller's lamp outputs (r1..r4, y1..y4, g1..g4). It samples all 12 lamp lines every clock and tracks the expected phase sequence. It reports the first safety or protocol violation as a sticky fault, and counts completed round-robin cycles. It sits beside the controller in system benches and on-chip as a safety watchdog.

Parameters:
GREEN_MIN, 5, minimum legal green run length in clock samples
GREEN_MAX, 7, maximum legal green run length in clock samples
YEL_CYC, 2, exact required yellow run length in clock samples
CNT_W, 4, run-length counter width; must hold GREEN_MAX+1 without wrap

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
r  input  4  red lamps, bit i = direction i+1
y  input  4  yellow lamps, bit i = direction i+1
g  input  4  green lamps, bit i = direction i+1
locked  output  1  monitor has synchronised to the sequence
active_dir  output  2  direction currently non-red (valid when locked)
fault  output  1  sticky violation flag
fault_code  output  3  code of first violation, 0 = none
fault_dir  output  2  direction involved in first violation
cycle_cnt  output  8  completed 1->2->3->4 rounds, wraps 255->0

Behaviour:
- Reset: synchronous, active-high on clk. All outputs 0. State SYNC. Counters 0. Reset mid-operation clears a sticky fault and returns to SYNC on the next edge.
- Sampling: r/y/g are registered once. Checks operate on the registered sample. fault/fault_code/fault_dir update 1 cycle after the edge that captured the offending sample.
- Direction i is "active" when y[i] or g[i] is set.
- Protocol: exactly one direction is active at a time. Active direction sequence is green for GREEN_MIN..GREEN_MAX samples, then yellow for exactly YEL_CYC samples, then red. Zero or more all-red samples follow. Then direction (i+1) mod 4 turns green.
- States:
  - SYNC: waits for the first sample with a green. Locks expected direction = that direction, with no order check. Goes to GREEN with run count = 1 and locked = 1.
  - GREEN: counts green samples. Green->yellow on the same direction goes to YELLOW with count = 1.
  - YELLOW: counts yellow samples. Yellow->all-red goes to ALL_RED and sets expected = dir+1.
  - ALL_RED: waits. A green on the expected direction goes to GREEN with count = 1.
  - FAULT: absorbing until reset. locked stays at its last value, and no further checks run.
- Fault codes (checked every sample in every state except FAULT):
  - 1 = some direction not one-hot across r/y/g. Checked in SYNC too.
  - 2 = more than one direction active. Checked in SYNC too.
  - 3 = wrong direction turns green from ALL_RED or YELLOW.
  - 4 = green ends with count < GREEN_MIN.
  - 5 = green count would exceed GREEN_MAX. Flagged on the (GREEN_MAX+1)th green sample.
  - 6 = yellow run != YEL_CYC. Flagged on exit if short, or on the (YEL_CYC+1)th sample if long.
  - 7 = illegal lamp transition: green->red without yellow, red->yellow, or yellow->green.
- Simultaneous violations: lowest code wins. fault_dir = lowest-numbered offending direction. Codes 1/2 take priority over sequence codes.
- Only the first fault is latched. Later violations do not change fault_code or fault_dir.
- cycle_cnt increments when direction 4 (index 3) leaves YELLOW legally. It wraps modulo 256.
- active_dir follows the locked direction in GREEN/YELLOW and holds the last value in ALL_RED.

Test Plan:
- Legal stream (green 6, yellow 2, 1 all-red, dirs 1->4, repeated 3 rounds) -> fault = 0 throughout, locked = 1 after the first green, cycle_cnt = 3.
- After lock, drive g = 4'b0011 for one sample -> fault = 1, fault_code = 2, fault_dir = 0, asserted 1 cycle after that sample; later violations do not change the code.
- Dir 2 green for 8 samples -> fault_code = 5 on the 8th sample (+1 latency), fault_dir = 1. Separately, green 4 samples then yellow -> fault_code = 4.
- After dir 1 yellow, dir 3 turns green -> fault_code = 3, fault_dir = 2. Separately, dir 1 has r and g both set -> fault_code = 1.
- Yellow held 3 samples -> fault_code = 6. Green->red directly -> fault_code = 7.
- Inject a fault, pulse reset for 1 cycle mid-round, resume a legal stream -> all outputs 0 after the reset edge, re-lock on the next green, no fault.
